// File: rtl/conv_pe_sequencer_pkg.sv
// conv_pe_sequencer_pkg: FSM states, PE pipeline latency and counter-width helper shared by the sequencer
package conv_pe_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;
  localparam int PE_LATENCY = 5;
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/conv_pe_sequencer_pe_ctrl_delay.sv
// pe_ctrl_delay: reset-cleared shift register aligning PE controls with weight RAM read data
module pe_ctrl_delay #(
  parameter int W   = 2,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         pend_o
);
  if (LAT == 0) begin : g_pass
    assign q_o    = d_i;
    assign pend_o = 1'b0;
  end else begin : g_sr
    logic [W-1:0] sr_q [LAT];
    always_ff @(posedge clk) begin
      sr_q[0] <= rst ? '0 : d_i;
      for (int i = 1; i < LAT; i++) sr_q[i] <= rst ? '0 : sr_q[i-1];
    end
    assign q_o = sr_q[LAT-1];
    // bit 0 carries the valid flag
    always_comb begin
      pend_o = 1'b0;
      for (int i = 0; i < LAT; i++) pend_o = pend_o | sr_q[i][0];
    end
  end
endmodule

// File: rtl/conv_pe_sequencer.sv
// conv_pe_sequencer: job controller streaming 3x3x8 windows and weight reads into one conv_pe,
// with output-FIFO credit flow control and in-flight result tracking.
module conv_pe_sequencer
  import conv_pe_sequencer_pkg::*;
#(
  parameter int GRP_W       = 8,
  parameter int PIX_W       = 16,
  parameter int WADDR_W     = 12,
  parameter int WRD_LAT     = 1,
  parameter int OFIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PIX_W-1:0]   cfg_num_pixels,
  input  logic [GRP_W-1:0]   cfg_cin_groups,
  input  logic [WADDR_W-1:0] cfg_wbase,
  input  logic [31:0]        cfg_bias,
  input  logic               win_valid,
  output logic               win_ready,
  output logic               w_rd_en,
  output logic [WADDR_W-1:0] w_rd_addr,
  output logic               pe_valid_in,
  output logic               pe_last_channel,
  output logic [31:0]        pe_bias,
  input  logic               pe_data_valid,
  input  logic               ofifo_pop,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int CW = cnt_w(OFIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CR = CW'(OFIFO_DEPTH);
  seq_state_t state_q, state_d;
  logic [GRP_W-1:0] grp_q, grp_d, cin_q;
  logic [PIX_W-1:0] pix_q, pix_d, npix_q;
  logic [WADDR_W-1:0] wbase_q;
  logic [31:0] bias_q;
  logic [CW-1:0] credits_q, credits_d, inflight_q, inflight_d;
  logic err_q, err_d;
  logic cfg_fire, accept, last, cr_take, cr_give, pend;
  logic [1:0] dly_q;
  always_comb begin
    cfg_ready = state_q == IDLE;
    busy      = state_q == RUN || state_q == DRAIN;
    done      = state_q == DONE;
    err       = err_q;
    pe_bias   = bias_q;
    cfg_fire  = cfg_valid & cfg_ready;
    win_ready = state_q == RUN && (grp_q != '0 || credits_q != '0);
    accept    = win_valid & win_ready;
    last      = accept && grp_q == cin_q - 1'b1;
    w_rd_en   = accept;
    w_rd_addr = accept ? wbase_q + WADDR_W'(grp_q) : '0;
    // a pixel reserves its output-FIFO slot when its first group is accepted
    cr_take   = accept && grp_q == '0;
    cr_give   = ofifo_pop;
    credits_d = (cr_give && !cr_take && credits_q != FULL_CR) ? credits_q + 1'b1 :
                (cr_take && !cr_give) ? credits_q - 1'b1 : credits_q;
    inflight_d = (last && !pe_data_valid) ? inflight_q + 1'b1 :
                 (pe_data_valid && !last && inflight_q != '0) ? inflight_q - 1'b1 : inflight_q;
    err_d = err_q | (cfg_fire && cfg_cin_groups == '0) |
            (pe_data_valid && !last && inflight_q == '0) |
            (cr_give && !cr_take && credits_q == FULL_CR);
    grp_d = (cfg_fire || last) ? '0 : accept ? grp_q + 1'b1 : grp_q;
    pix_d = cfg_fire ? '0 : last ? pix_q + 1'b1 : pix_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (!cfg_fire || cfg_cin_groups == '0) ? IDLE : cfg_num_pixels == '0 ? DONE : RUN;
      RUN:     state_d = (last && pix_q == npix_q - 1'b1) ? DRAIN : RUN;
      DRAIN:   state_d = (inflight_d == '0 && !pend) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grp_q      <= '0;
      pix_q      <= '0;
      cin_q      <= '0;
      npix_q     <= '0;
      wbase_q    <= '0;
      bias_q     <= '0;
      credits_q  <= FULL_CR;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      pix_q      <= pix_d;
      credits_q  <= credits_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      if (cfg_fire) begin
        cin_q   <= cfg_cin_groups;
        npix_q  <= cfg_num_pixels;
        wbase_q <= cfg_wbase;
        bias_q  <= cfg_bias;
      end
    end
  end
  pe_ctrl_delay #(.W(2), .LAT(WRD_LAT)) u_dly (
    .clk    (clk),
    .rst    (rst),
    .d_i    ({last, accept}),
    .q_o    (dly_q),
    .pend_o (pend)
  );
  assign {pe_last_channel, pe_valid_in} = dly_q;
endmodule

// File: tb/tb_conv_pe_sequencer.sv
// tb_conv_pe_sequencer: directed and randomized jobs against a queue-based model of windows, PE and output FIFO
module tb_conv_pe_sequencer;
  localparam int DEPTH  = 8;
  localparam int PE_LAT = 5;
  logic clk = 1'b0;
  logic rst;
  logic cfg_valid, cfg_ready, win_valid, win_ready, w_rd_en, pe_valid_in, pe_last_channel;
  logic pe_data_valid, ofifo_pop, busy, done, err;
  logic [15:0] cfg_num_pixels;
  logic [7:0]  cfg_cin_groups;
  logic [11:0] cfg_wbase, w_rd_addr;
  logic [31:0] cfg_bias, pe_bias;
  always #5 clk = ~clk;
  conv_pe_sequencer dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_num_pixels(cfg_num_pixels), .cfg_cin_groups(cfg_cin_groups), .cfg_wbase(cfg_wbase),
    .cfg_bias(cfg_bias), .win_valid(win_valid), .win_ready(win_ready), .w_rd_en(w_rd_en),
    .w_rd_addr(w_rd_addr), .pe_valid_in(pe_valid_in), .pe_last_channel(pe_last_channel),
    .pe_bias(pe_bias), .pe_data_valid(pe_data_valid), .ofifo_pop(ofifo_pop),
    .busy(busy), .done(done), .err(err)
  );
  typedef struct packed {logic [11:0] addr; logic last;} beat_t;
  int errors = 0, checks = 0, cyc_n = 0;
  int cr, fifo_n, grp_pos, pend_results, done_at, win_pct, started, n_last, n_split, n_done;
  bit job_active, err_m, prev_acc, prev_last, pop_mode, pop_once;
  logic [31:0] bias_m;
  logic [11:0] wbase_m;
  beat_t exp_q[$];
  int dv_at[$];
  logic [11:0] addr_log[$];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic reset_model();
    cr = DEPTH; fifo_n = 0; grp_pos = 0; pend_results = 0; done_at = -1;
    job_active = 0; err_m = 0; prev_acc = 0; prev_last = 0;
    exp_q.delete(); dv_at.delete();
  endtask
  task automatic reset_checks(input string p);
    chk({p, "_cfg_ready"}, cfg_ready, 1);
    chk({p, "_win_ready"}, win_ready, 0);
    chk({p, "_w_rd_en"}, w_rd_en, 0);
    chk({p, "_w_rd_addr"}, w_rd_addr, 0);
    chk({p, "_pe_valid"}, pe_valid_in, 0);
    chk({p, "_pe_last"}, pe_last_channel, 0);
    chk({p, "_pe_bias"}, pe_bias, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_err"}, err, 0);
  endtask
  task automatic tick();
    beat_t b;
    bit acc, rdy, pop, dv;
    win_valid = $urandom_range(99) < win_pct;
    dv = dv_at.size() > 0 && dv_at[0] == cyc_n;
    if (dv) void'(dv_at.pop_front());
    pe_data_valid = dv;
    pop = fifo_n > 0 && (pop_once || (pop_mode && $urandom_range(1) == 1));
    pop_once = 0;
    ofifo_pop = pop;
    @(negedge clk);
    rdy = exp_q.size() > 0 && (grp_pos != 0 || cr > 0);
    acc = win_valid && rdy;
    chk("win_ready", win_ready, rdy);
    chk("w_rd_en", w_rd_en, acc);
    if (acc) chk("w_rd_addr", w_rd_addr, exp_q[0].addr);
    chk("pe_valid_in", pe_valid_in, prev_acc);
    chk("pe_last_channel", pe_last_channel, prev_last);
    chk("done", done, cyc_n == done_at);
    chk("busy", busy, job_active && cyc_n != done_at);
    chk("cfg_ready", cfg_ready, !job_active);
    chk("err", err, err_m);
    if (job_active) chk("pe_bias", pe_bias, bias_m);
    if (w_rd_en) begin
      addr_log.push_back(w_rd_addr);
      if (w_rd_addr == wbase_m) started++;
    end
    if (pe_valid_in && pe_last_channel) n_last++;
    if (pe_valid_in != pe_last_channel) n_split++;
    if (done) n_done++;
    if (prev_acc && prev_last) dv_at.push_back(cyc_n + PE_LAT);
    prev_acc = acc;
    prev_last = 0;
    if (acc) begin
      b = exp_q.pop_front();
      prev_last = b.last;
      if (grp_pos == 0) cr--;
      grp_pos = b.last ? 0 : grp_pos + 1;
    end
    if (pop) begin cr++; fifo_n--; end
    if (dv) begin
      fifo_n++;
      pend_results--;
      if (pend_results == 0) done_at = cyc_n + 1;
    end
    if (cfg_valid && !job_active) begin
      if (cfg_cin_groups == 0) err_m = 1;
      else begin
        job_active = 1; bias_m = cfg_bias; wbase_m = cfg_wbase; grp_pos = 0;
        pend_results = int'(cfg_num_pixels);
        for (int p = 0; p < int'(cfg_num_pixels); p++)
          for (int g = 0; g < int'(cfg_cin_groups); g++)
            exp_q.push_back('{addr: cfg_wbase + 12'(g), last: g == int'(cfg_cin_groups) - 1});
        if (cfg_num_pixels == 0) done_at = cyc_n + 1;
      end
    end else if (cyc_n == done_at) job_active = 0;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask
  task automatic job(input int pix, input int grp, input int wb, input logic [31:0] bias);
    cfg_valid = 1; cfg_num_pixels = 16'(pix); cfg_cin_groups = 8'(grp);
    cfg_wbase = 12'(wb); cfg_bias = bias;
    tick();
    cfg_valid = 0;
  endtask
  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while (job_active && n < budget) begin tick(); n++; end
    chk(tag, job_active, 0);
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1; cfg_valid = 0; cfg_num_pixels = 0; cfg_cin_groups = 0; cfg_wbase = 0; cfg_bias = 0;
    win_valid = 0; pe_data_valid = 0; ofifo_pop = 0; pop_once = 0; pop_mode = 1; win_pct = 100;
    started = 0; n_last = 0; n_split = 0; n_done = 0; wbase_m = 0; bias_m = 0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    reset_checks("reset");
    addr_log.delete();
    job(2, 3, 'h10, 32'hCAFE_0001);
    run_idle("job1_finish", 200);
    chk("job1_accepts", addr_log.size(), 6);
    for (int i = 0; i < 6 && i < addr_log.size(); i++) chk("job1_addr", addr_log[i], 12'h10 + 12'(i % 3));
    chk("job1_lasts", n_last, 2);
    chk("job1_done_pulses", n_done, 1);
    n_last = 0; n_split = 0; n_done = 0;
    job(4, 1, 'h200, 32'h1234_5678);
    run_idle("g1_finish", 200);
    chk("g1_last_eq_valid", n_split, 0);
    chk("g1_lasts", n_last, 4);
    chk("g1_done_pulses", n_done, 1);
    for (int j = 0; j < 12; j++) begin
      win_pct = $urandom_range(40, 100);
      n_done = 0;
      job($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 4000), $urandom());
      run_idle("rand_finish", 800);
      chk("rand_done_pulses", n_done, 1);
      repeat ($urandom_range(0, 3)) tick();
    end
    win_pct = 100;
    for (int n = 0; n < 100 && fifo_n > 0; n++) tick();
    pop_mode = 0; started = 0;
    job(10, 2, 'h300, 32'hDEAD_BEEF);
    repeat (60) tick();
    chk("credit_stall_pixels", started, 8);
    pop_once = 1;
    repeat (30) tick();
    chk("credit_one_more", started, 9);
    pop_mode = 1;
    run_idle("credit_finish", 600);
    addr_log.delete(); n_done = 0;
    job(0, 3, 'h40, 32'h0000_0042);
    tick();
    chk("pix0_done", n_done, 1);
    chk("pix0_no_reads", addr_log.size(), 0);
    run_idle("pix0_finish", 10);
    started = 0;
    job(5, 2, 'h500, 32'h5555_AAAA);
    for (int n = 0; n < 100 && started < 3; n++) tick();
    chk("midrst_started", started, 3);
    rst = 1; win_valid = 0; pe_data_valid = 0; ofifo_pop = 0;
    @(posedge clk);
    #1;
    rst = 0;
    reset_model();
    reset_checks("midrst");
    n_done = 0;
    job(3, 2, 'h600, 32'h0BAD_F00D);
    run_idle("after_rst_finish", 300);
    chk("after_rst_done_pulses", n_done, 1);
    job(3, 0, 'h700, 32'h1);
    tick();
    chk("grp0_err", err, 1);
    chk("grp0_idle", cfg_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
